// File: rtl/slow_pkg.sv
// Shared types and constants for the slow-peripheral settings block and its
// per-access stretch engine.
package slow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_NCH = 7;
    localparam int DEF_TW  = 4;

    localparam logic [DEF_NCH-1:0] DEF_RST_MASK = 7'b1110111;
    localparam logic [DEF_TW-1:0]  DEF_RST_TO   = 4'h3;

    // Address field layout: mask in the low bits, timeout directly above it.
    localparam int MASK_LSB = 0;

    function automatic int to_lsb(input int nch);
        return nch;
    endfunction

endpackage

// File: rtl/slow_timer.sv
// Per-access stretch engine: holds Slow for TimeoutVal clocks, then pulses
// SlowTO and parks in HOLD until the bus access ends.
module slow_timer
    import slow_pkg::*;
#(
    parameter int TW = DEF_TW
) (
    input  logic          CLK,
    input  logic          POR,
    input  logic          BACT,
    input  logic          Start,
    input  logic [TW-1:0] TimeoutVal,
    output logic          Slow,
    output logic          SlowTO,
    output logic          Busy
);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          slowto_q, slowto_d;

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            slowto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            slowto_q <= slowto_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slowto_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    // Counter snapshots the timeout here; later config writes
                    // do not disturb a running stretch.
                    if (TimeoutVal != '0) begin
                        state_d = COUNT;
                        cnt_d   = TimeoutVal;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            COUNT: begin
                if (!BACT) begin
                    state_d = IDLE;
                end else if (cnt_q == TW'(1)) begin
                    state_d  = HOLD;
                    slowto_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - TW'(1);
                end
            end
            HOLD: begin
                if (!BACT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Slow   = (state_q == COUNT);
    assign Busy   = (state_q != IDLE);
    assign SlowTO = slowto_q;

endmodule

// File: rtl/slow_ctrl.sv
// Slow-peripheral settings register (mask + timeout, written through an
// address-encoded strobe) plus the per-access stretch engine.
module slow_ctrl
    import slow_pkg::*;
#(
    parameter int              NCH      = DEF_NCH,
    parameter int              TW       = DEF_TW,
    parameter logic [NCH-1:0]  RST_MASK = NCH'(DEF_RST_MASK),
    parameter logic [TW-1:0]   RST_TO   = TW'(DEF_RST_TO)
) (
    input  logic              CLK,
    input  logic              POR,
    input  logic              BACT,
    input  logic [NCH+TW-1:0] A,
    input  logic              SetCSWR,
    input  logic [NCH-1:0]    SlowReq,
    output logic [NCH-1:0]    SlowMask,
    output logic [TW-1:0]     SlowTimeout,
    output logic              Slow,
    output logic              SlowTO,
    output logic              Busy
);

    localparam int TO_LSB = to_lsb(NCH);

    logic           setwr_q, setwr_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [TW-1:0]  to_q, to_d;
    logic           start;

    // The strobe is registered first; the data is taken from A one edge
    // later, so A must be held valid through the second edge.
    always_comb begin
        setwr_d = BACT & SetCSWR;
        mask_d  = mask_q;
        to_d    = to_q;
        if (setwr_q) begin
            mask_d = A[MASK_LSB +: NCH];
            to_d   = A[TO_LSB +: TW];
        end
    end

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            setwr_q <= 1'b0;
            mask_q  <= RST_MASK;
            to_q    <= RST_TO;
        end else begin
            setwr_q <= setwr_d;
            mask_q  <= mask_d;
            to_q    <= to_d;
        end
    end

    assign start       = BACT & (|(SlowReq & mask_q));
    assign SlowMask    = mask_q;
    assign SlowTimeout = to_q;

    slow_timer #(.TW(TW)) u_timer (
        .CLK        (CLK),
        .POR        (POR),
        .BACT       (BACT),
        .Start      (start),
        .TimeoutVal (to_q),
        .Slow       (Slow),
        .SlowTO     (SlowTO),
        .Busy       (Busy)
    );

endmodule

// File: tb/tb_slow_ctrl.sv
// Directed bench for slow_ctrl: default instance plus a wide NCH=12/TW=6 one.
module tb_slow_ctrl;

    logic        CLK = 1'b0;
    logic        POR = 1'b1;
    logic        BACT = 1'b0;
    logic [10:0] A = '0;
    logic        SetCSWR = 1'b0;
    logic [6:0]  SlowReq = '0;
    logic [6:0]  SlowMask;
    logic [3:0]  SlowTimeout;
    logic        Slow, SlowTO, Busy;

    logic        p_BACT = 1'b0;
    logic [17:0] p_A = '0;
    logic        p_SetCSWR = 1'b0;
    logic [11:0] p_SlowReq = '0;
    logic [11:0] p_SlowMask;
    logic [5:0]  p_SlowTimeout;
    logic        p_Slow, p_SlowTO, p_Busy;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    slow_ctrl dut (
        .CLK(CLK), .POR(POR), .BACT(BACT), .A(A), .SetCSWR(SetCSWR),
        .SlowReq(SlowReq), .SlowMask(SlowMask), .SlowTimeout(SlowTimeout),
        .Slow(Slow), .SlowTO(SlowTO), .Busy(Busy)
    );

    slow_ctrl #(.NCH(12), .TW(6), .RST_MASK(12'hFFF), .RST_TO(6'd63)) dut_p (
        .CLK(CLK), .POR(POR), .BACT(p_BACT), .A(p_A), .SetCSWR(p_SetCSWR),
        .SlowReq(p_SlowReq), .SlowMask(p_SlowMask), .SlowTimeout(p_SlowTimeout),
        .Slow(p_Slow), .SlowTO(p_SlowTO), .Busy(p_Busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe sampled at the first edge, data loaded at the second.
    task automatic cfg_write(input logic [3:0] to, input logic [6:0] mask);
        BACT = 1'b1; SetCSWR = 1'b1; SlowReq = '0; A = {to, mask};
        tick();
        SetCSWR = 1'b0;
        tick();
        chk("cfg_mask", 32'(SlowMask), 32'(mask));
        chk("cfg_to", 32'(SlowTimeout), 32'(to));
        BACT = 1'b0;
        tick();
    endtask

    // Drive a matching access and expect exactly t Slow cycles then one SlowTO.
    task automatic run_stretch(input string tag, input int t, input logic [6:0] req);
        BACT = 1'b1; SlowReq = req;
        for (int i = 0; i < t; i++) begin
            tick();
            chk({tag, "_slow"}, 32'(Slow), 32'd1);
            chk({tag, "_to_early"}, 32'(SlowTO), 32'd0);
        end
        tick();
        chk({tag, "_slow_end"}, 32'(Slow), 32'd0);
        chk({tag, "_to_pulse"}, 32'(SlowTO), 32'd1);
        chk({tag, "_hold_busy"}, 32'(Busy), 32'd1);
        BACT = 1'b0; SlowReq = '0;
        tick();
        chk({tag, "_to_once"}, 32'(SlowTO), 32'd0);
        chk({tag, "_idle"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        int ns, nt;
        logic seen;

        // Reset values while POR is held
        tick(); tick();
        #2;
        chk("rst_mask", 32'(SlowMask), 32'h77);
        chk("rst_to", 32'(SlowTimeout), 32'd3);
        chk("rst_slow", 32'(Slow), 32'd0);
        chk("rst_slowto", 32'(SlowTO), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_p_to", 32'(p_SlowTimeout), 32'd63);
        POR = 1'b0;
        tick();

        run_stretch("def3", 3, 7'b0000010);

        // Write latency: not visible after one edge
        BACT = 1'b1; SetCSWR = 1'b1; A = {4'd5, 7'b0000001};
        tick();
        chk("wr_lat1_mask", 32'(SlowMask), 32'h77);
        chk("wr_lat1_to", 32'(SlowTimeout), 32'd3);
        SetCSWR = 1'b0;
        tick();
        chk("wr_lat2_mask", 32'(SlowMask), 32'h01);
        chk("wr_lat2_to", 32'(SlowTimeout), 32'd5);
        BACT = 1'b0;
        tick();

        run_stretch("to5", 5, 7'b0000001);

        // Masked-off device: engine stays idle
        BACT = 1'b1; SlowReq = 7'b0000010;
        tick();
        chk("nomatch_slow", 32'(Slow), 32'd0);
        chk("nomatch_busy", 32'(Busy), 32'd0);
        tick();
        chk("nomatch_slowto", 32'(SlowTO), 32'd0);
        BACT = 1'b0; SlowReq = '0;
        tick();

        // Abort after 3 Slow cycles
        cfg_write(4'd8, 7'b0000001);
        BACT = 1'b1; SlowReq = 7'b0000001;
        tick(); tick(); tick();
        chk("abort_slow3", 32'(Slow), 32'd1);
        BACT = 1'b0; SlowReq = '0;
        tick();
        chk("abort_slow", 32'(Slow), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        seen = SlowTO;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | SlowTO;
        end
        chk("abort_no_to", 32'(seen), 32'd0);

        // Zero timeout: HOLD without Slow/SlowTO
        cfg_write(4'd0, 7'h7F);
        BACT = 1'b1; SlowReq = 7'b0001000;
        tick();
        chk("zero_slow", 32'(Slow), 32'd0);
        chk("zero_busy", 32'(Busy), 32'd1);
        tick(); tick();
        chk("zero_slowto", 32'(SlowTO), 32'd0);
        chk("zero_busy_hold", 32'(Busy), 32'd1);
        BACT = 1'b0; SlowReq = '0;
        tick();
        chk("zero_release", 32'(Busy), 32'd0);

        // Snapshot: a write during COUNT leaves the running stretch at 4
        cfg_write(4'd4, 7'h7F);
        BACT = 1'b1; SlowReq = 7'b0000001;
        tick();
        chk("snap_c1", 32'(Slow), 32'd1);
        SetCSWR = 1'b1; A = {4'd9, 7'h7F};
        tick();
        chk("snap_c2", 32'(Slow), 32'd1);
        SetCSWR = 1'b0;
        tick();
        chk("snap_c3", 32'(Slow), 32'd1);
        chk("snap_newto", 32'(SlowTimeout), 32'd9);
        tick();
        chk("snap_c4", 32'(Slow), 32'd1);
        tick();
        chk("snap_end", 32'(Slow), 32'd0);
        chk("snap_pulse", 32'(SlowTO), 32'd1);
        BACT = 1'b0; SlowReq = '0;
        tick();
        run_stretch("snap9", 9, 7'b0000001);

        // Wide instance: maximum 63-cycle stretch
        p_BACT = 1'b1; p_SlowReq = 12'h800;
        ns = 0; nt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (p_Slow) ns++;
            if (p_SlowTO) nt++;
        end
        chk("wide_slow_cycles", 32'(ns), 32'd63);
        chk("wide_to_pulses", 32'(nt), 32'd1);
        chk("wide_hold", 32'(p_Busy), 32'd1);
        p_BACT = 1'b0; p_SlowReq = '0;
        tick();
        chk("wide_idle", 32'(p_Busy), 32'd0);

        // Asynchronous reset in the middle of a stretch
        BACT = 1'b1; SlowReq = 7'b0000001;
        tick();
        chk("mid_slow", 32'(Slow), 32'd1);
        #3 POR = 1'b1;
        #1;
        chk("arst_slow", 32'(Slow), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_mask", 32'(SlowMask), 32'h77);
        chk("arst_to", 32'(SlowTimeout), 32'd3);
        tick();
        chk("arst_no_to", 32'(SlowTO), 32'd0);
        BACT = 1'b0; SlowReq = '0;
        POR = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
